// File: rtl/sdm_pkg.sv
// Shared types and defaults for the sigma-delta modulator and its sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdm_pkg;

  localparam int SDM_DW    = 32;
  localparam int SDM_OSR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2,
    RUN   = 2'd3
  } sdm_state_e;

endpackage

// File: rtl/sdm_density_cnt.sv
// Counts modulator ones across one oversampling window and publishes the total.
// Latency: ones_count/cnt_valid registered one edge after the window-end cycle.
// Backpressure: none; cnt_valid is a one-cycle pulse with no ready.
module sdm_density_cnt #(
  parameter int OSR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mod_en,
  input  logic             mod_bit,
  input  logic             win_end,
  output logic [OSR_W:0]   ones_count,
  output logic             cnt_valid
);

  logic [OSR_W:0] acc;
  logic [OSR_W:0] bit_ext;

  assign bit_ext = {{OSR_W{1'b0}}, mod_bit};

  // Accumulate while the modulator runs; at window end publish acc plus the
  // current bit and restart the count for the next window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      ones_count <= '0;
      cnt_valid  <= 1'b0;
    end else if (win_end) begin
      ones_count <= acc + bit_ext;
      cnt_valid  <= 1'b1;
      acc        <= '0;
    end else begin
      cnt_valid  <= 1'b0;
      if (mod_en) begin
        acc <= acc + bit_ext;
      end
    end
  end

endmodule

// File: rtl/sdm_seq_ctrl.sv
// Oversampling sequencer: holds each accepted sample on the modulator for osr cycles.
// Latency: mod_clr one edge after start; mod_data/mod_en one edge after handshake.
// Backpressure: in_ready only in WAIT or on the last phase of a window with no stop pending.
module sdm_seq_ctrl
  import sdm_pkg::*;
#(
  parameter int DW         = SDM_DW,
  parameter int OSR_W      = SDM_OSR_W,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [OSR_W-1:0] cfg_osr,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    mod_data,
  output logic             mod_en,
  output logic             mod_clr,
  input  logic             mod_bit,
  output logic [OSR_W:0]   ones_count,
  output logic             cnt_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int             SW        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]  SETTLE_LD = SW'(SETTLE_CYC - 1);

  sdm_state_e       state;
  sdm_state_e       state_nxt;
  logic [OSR_W-1:0] osr;
  logic [OSR_W:0]   phase;
  logic [OSR_W:0]   phase_last;
  logic [SW-1:0]    settle_cnt;
  logic             stop_pend;
  logic             win_end;
  logic             start_acc;
  logic             load_smp;

  assign phase_last = {1'b0, osr} - (OSR_W+1)'(1);
  assign win_end    = (state == RUN) && (phase == phase_last);
  assign in_ready   = (state == WAIT) || (win_end && !stop_pend);
  assign start_acc  = (state == IDLE) && start;
  assign load_smp   = in_valid && in_ready && (state_nxt == RUN);

  // Next-state decode; a stop ends FLUSH/WAIT at once but RUN only at a window end.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FLUSH;
      FLUSH:   if (stop) state_nxt = IDLE;
               else if (settle_cnt == '0) state_nxt = WAIT;
      WAIT:    if (stop) state_nxt = IDLE;
               else if (in_valid) state_nxt = RUN;
      RUN:     if (win_end && stop_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the strobes that are pure decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mod_en  <= 1'b0;
      mod_clr <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mod_en  <= (state_nxt == RUN);
      mod_clr <= (state_nxt == FLUSH);
      busy    <= (state_nxt != IDLE);
    end
  end

  // Run configuration and integrator settle timer, both armed by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      osr        <= OSR_W'(1);
      settle_cnt <= '0;
    end else if (start_acc) begin
      osr        <= (cfg_osr == '0) ? OSR_W'(1) : cfg_osr;
      settle_cnt <= SETTLE_LD;
    end else if ((state == FLUSH) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SW'(1);
    end
  end

  // Window phase: restarts on the first sample and at every window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if ((state == WAIT) || win_end) begin
      phase <= '0;
    end else if (state == RUN) begin
      phase <= phase + (OSR_W+1)'(1);
    end
  end

  // Pending stop; a stop landing on a window-end cycle applies to the next window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_pend <= 1'b0;
    end else if (state_nxt == IDLE) begin
      stop_pend <= 1'b0;
    end else if (stop && (state != IDLE)) begin
      stop_pend <= 1'b1;
    end
  end

  // Sample hold and sticky underrun when a window ends with nothing to load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_data <= '0;
      underrun <= 1'b0;
    end else begin
      if (load_smp) begin
        mod_data <= in_data;
      end
      if (start_acc) begin
        underrun <= 1'b0;
      end else if (win_end && !stop_pend && !in_valid) begin
        underrun <= 1'b1;
      end
    end
  end

  sdm_density_cnt #(
    .OSR_W (OSR_W)
  ) u_density (
    .clk        (clk),
    .rst        (rst),
    .mod_en     (mod_en),
    .mod_bit    (mod_bit),
    .win_end    (win_end),
    .ones_count (ones_count),
    .cnt_valid  (cnt_valid)
  );

endmodule

// File: tb/tb_sdm_seq_ctrl.sv
// Randomized self-checking bench for sdm_seq_ctrl against a window-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdm_seq_ctrl;

  localparam int DW     = 32;
  localparam int OSR_W  = 8;
  localparam int SETTLE = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [OSR_W-1:0] cfg_osr;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    mod_data;
  logic             mod_en;
  logic             mod_clr;
  logic             mod_bit;
  logic [OSR_W:0]   ones_count;
  logic             cnt_valid;
  logic             busy;
  logic             underrun;

  int total = 0;
  int bad   = 0;

  // Reference expectations carried between scenarios.
  logic [DW-1:0] exp_data = '0;
  int            exp_cnt  = 0;
  bit            exp_under = 1'b0;

  always #5 clk = ~clk;

  sdm_seq_ctrl #(
    .DW         (DW),
    .OSR_W      (OSR_W),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_osr    (cfg_osr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mod_data   (mod_data),
    .mod_en     (mod_en),
    .mod_clr    (mod_clr),
    .mod_bit    (mod_bit),
    .ones_count (ones_count),
    .cnt_valid  (cnt_valid),
    .busy       (busy),
    .underrun   (underrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; checks a quiet IDLE cycle.
  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"},  64'(busy), 64'(0));
    chk({tag, "_en"},    64'(mod_en), 64'(0));
    chk({tag, "_clr"},   64'(mod_clr), 64'(0));
    chk({tag, "_rdy"},   64'(in_ready), 64'(0));
    chk({tag, "_cv"},    64'(cnt_valid), 64'(0));
    chk({tag, "_under"}, 64'(underrun), 64'(exp_under));
    chk({tag, "_data"},  64'(mod_data), 64'(exp_data));
    chk({tag, "_cnt"},   64'(ones_count), 64'(exp_cnt));
    @(posedge clk); #1;
  endtask

  // Full run: start, flush, first handshake, windows until stop (or reset).
  // Window model: after the handshake edge, cycle index k (0-based) belongs to
  // window k/osr at position k%osr; the last position is the boundary.
  task automatic do_run(input int cfg, input int stop_w, input int stop_p,
                        input int vld_pct, input int drop_w, input int bmode,
                        input bit seqd, input int rst_w, input int rst_p,
                        input bit stop_with_start);
    int            osr_e;
    int            pos;
    int            w;
    int            sum;
    bit            stopped;
    bit            ended;
    bit            bitv;
    bit            dv;
    bit            stop_now;
    bit            exp_cv;
    bit            bnd;
    logic [DW-1:0] d;
    int            wait_cyc;

    osr_e   = (cfg == 0) ? 1 : cfg;
    start   = 1'b1;
    stop    = stop_with_start;
    cfg_osr = OSR_W'(cfg);
    @(negedge clk);
    chk("start_rdy", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    start     = 1'b0;
    stop      = 1'b0;
    exp_under = 1'b0;

    for (int i = 0; i < SETTLE; i++) begin
      cfg_osr  = OSR_W'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(negedge clk);
      chk("flush_clr",   64'(mod_clr), 64'(1));
      chk("flush_rdy",   64'(in_ready), 64'(0));
      chk("flush_en",    64'(mod_en), 64'(0));
      chk("flush_busy",  64'(busy), 64'(1));
      chk("flush_under", 64'(underrun), 64'(0));
      @(posedge clk); #1;
    end

    in_valid = 1'b0;
    wait_cyc = $urandom_range(0, 2);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      chk("wait_rdy", 64'(in_ready), 64'(1));
      chk("wait_clr", 64'(mod_clr), 64'(0));
      chk("wait_en",  64'(mod_en), 64'(0));
      @(posedge clk); #1;
    end

    d        = seqd ? DW'(32'h10) : DW'($urandom);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    chk("hs_rdy", 64'(in_ready), 64'(1));
    chk("hs_clr", 64'(mod_clr), 64'(0));
    @(posedge clk); #1;

    exp_data = d;
    exp_cv   = 1'b0;
    sum      = 0;
    stopped  = 1'b0;
    ended    = 1'b0;
    w        = 0;
    pos      = 0;

    for (int c = 0; c < 4000; c++) begin
      bnd = (pos == osr_e - 1);
      case (bmode)
        1:       bitv = 1'b1;
        2:       bitv = (pos % 2 == 0);
        default: bitv = 1'($urandom_range(0, 1));
      endcase
      dv = ($urandom_range(0, 99) < vld_pct);
      if (w == drop_w && bnd) dv = 1'b0;
      d  = (seqd && bnd) ? DW'(32'h10 * (w + 2)) : DW'($urandom);
      stop_now = (w == stop_w) && (pos == stop_p);
      mod_bit  = bitv;
      in_valid = dv;
      in_data  = d;
      stop     = stop_now;
      start    = ($urandom_range(0, 19) == 0);
      cfg_osr  = OSR_W'($urandom);

      if (w == rst_w && pos == rst_p) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_en",    64'(mod_en), 64'(0));
        chk("arst_cv",    64'(cnt_valid), 64'(0));
        chk("arst_busy",  64'(busy), 64'(0));
        chk("arst_rdy",   64'(in_ready), 64'(0));
        chk("arst_data",  64'(mod_data), 64'(0));
        chk("arst_cnt",   64'(ones_count), 64'(0));
        chk("arst_under", 64'(underrun), 64'(0));
        @(posedge clk); #1;
        rst      = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        in_valid = 1'b0;
        mod_bit  = 1'b0;
        exp_data = '0;
        exp_cnt  = 0;
        exp_under = 1'b0;
        return;
      end

      @(negedge clk);
      chk("run_en",    64'(mod_en), 64'(1));
      chk("run_busy",  64'(busy), 64'(1));
      chk("run_clr",   64'(mod_clr), 64'(0));
      chk("run_data",  64'(mod_data), 64'(exp_data));
      chk("run_rdy",   64'(in_ready), 64'(bnd && !stopped));
      chk("run_under", 64'(underrun), 64'(exp_under));
      chk("run_cv",    64'(cnt_valid), 64'(exp_cv));
      chk("run_cnt",   64'(ones_count), 64'(exp_cnt));
      @(posedge clk); #1;

      sum += int'(bitv);
      if (bnd) begin
        exp_cv  = 1'b1;
        exp_cnt = sum;
        sum     = 0;
        if (stopped) begin
          ended = 1'b1;
          break;
        end
        if (dv) exp_data = d;
        else    exp_under = 1'b1;
        pos = 0;
        w++;
      end else begin
        exp_cv = 1'b0;
        pos++;
      end
      if (stop_now) stopped = 1'b1;
    end

    start    = 1'b0;
    stop     = 1'b0;
    in_valid = 1'b0;
    mod_bit  = 1'b0;
    chk("run_ended", 64'(ended), 64'(1));

    @(negedge clk);
    chk("end_busy",  64'(busy), 64'(0));
    chk("end_en",    64'(mod_en), 64'(0));
    chk("end_rdy",   64'(in_ready), 64'(0));
    chk("end_cv",    64'(cnt_valid), 64'(1));
    chk("end_cnt",   64'(ones_count), 64'(exp_cnt));
    chk("end_data",  64'(mod_data), 64'(exp_data));
    chk("end_under", 64'(underrun), 64'(exp_under));
    @(posedge clk); #1;
    check_idle("post");
  endtask

  // Stop during integrator clear returns to IDLE on the next cycle.
  task automatic do_flush_stop();
    start   = 1'b1;
    cfg_osr = OSR_W'(5);
    @(posedge clk); #1;
    start     = 1'b0;
    exp_under = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fs_clr", 64'(mod_clr), 64'(1));
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(negedge clk);
    chk("fs_clr_stop", 64'(mod_clr), 64'(1));
    @(posedge clk); #1;
    stop = 1'b0;
    check_idle("fs_idle");
  endtask

  initial begin
    int oe;
    int c;
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    cfg_osr  = '0;
    in_data  = '0;
    in_valid = 1'b0;
    mod_bit  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rdy",  64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("reset");

    // osr=4, sequential samples, stop at phase 1 of window 3
    do_run(4, 3, 1, 100, -1, 0, 1'b1, -1, -1, 1'b0);
    // osr=8, mod_bit held high then alternating
    do_run(8, 2, 5, 100, -1, 1, 1'b0, -1, -1, 1'b0);
    do_run(8, 2, 5, 100, -1, 2, 1'b0, -1, -1, 1'b0);
    // osr=4 with one missing sample at the window-1 boundary
    do_run(4, 3, 2, 100, 1, 0, 1'b1, -1, -1, 1'b0);
    repeat (3) check_idle("under_hold");
    do_flush_stop();
    // start and stop together from IDLE
    do_run(3, 1, 0, 100, -1, 0, 1'b0, -1, -1, 1'b1);
    // reset at phase 2 of window 1, then osr configured as 0
    do_run(4, 9, 0, 100, -1, 0, 1'b0, 1, 2, 1'b0);
    check_idle("after_arst");
    do_run(0, 5, 0, 100, -1, 0, 1'b0, -1, -1, 1'b0);

    for (int n = 0; n < 12; n++) begin
      c  = $urandom_range(0, 12);
      oe = (c == 0) ? 1 : c;
      do_run(c, $urandom_range(0, 4), $urandom_range(0, oe - 1),
             $urandom_range(60, 100), -1, 0, 1'b0, -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
